// File: rtl/y86_alu_pkg.sv
// rtl/y86_alu_pkg.sv - Shared Y86 ALU/condition-code constants and condition evaluation
package y86_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_XOR = 4'd3
  } alu_fn_e;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic CC_ZF_RST = 1'b1;
  localparam logic CC_SF_RST = 1'b0;
  localparam logic CC_OF_RST = 1'b0;

  // Codes 7..15 are not defined for cmovXX/jXX and never fire.
  function automatic logic cond_eval(input logic [3:0] ifun, input logic zf,
                                     input logic sf, input logic of);
    logic lt;
    lt = sf ^ of;
    case (ifun)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = lt | zf;
      C_L:     cond_eval = lt;
      C_E:     cond_eval = zf;
      C_NE:    cond_eval = ~zf;
      C_GE:    cond_eval = ~lt;
      C_G:     cond_eval = ~lt & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_cc_writeback_fifo.sv
// rtl/alu_cc_writeback_fifo.sv - Writeback FIFO of {dst, value} entries toward register port E
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [3:0]   push_dst,
  input  logic [W-1:0] push_val,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [3:0]   head_dst,
  output logic [W-1:0] head_val
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]   dst_q [DEPTH];
  logic [3:0]   dst_d [DEPTH];
  logic [W-1:0] val_q [DEPTH];
  logic [W-1:0] val_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign head_dst = dst_q[rd_ptr_q];
  assign head_val = val_q[rd_ptr_q];

  // Pointers are power-of-two wide, so natural overflow gives the modulo wrap.
  always_comb begin
    dst_d    = dst_q;
    val_d    = val_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      dst_d[wr_ptr_q] = push_dst;
      val_d[wr_ptr_q] = push_val;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i] <= '0;
        val_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      dst_q    <= dst_d;
      val_q    <= val_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_cc_writeback.sv
// rtl/alu_cc_writeback.sv - Execute-stage ALU consumer: condition codes, cnd, writeback FIFO
module alu_cc_writeback
  import y86_alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] alu_out,
  input  logic         alu_ovf,
  input  logic         set_cc,
  input  logic         is_cond,
  input  logic [3:0]   ifun,
  input  logic [3:0]   dst,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic         cnd,
  output logic         wb_valid,
  input  logic         wb_ready,
  output logic [3:0]   wb_dst,
  output logic [W-1:0] wb_val
);

  logic zf_q, zf_d, sf_q, sf_d, of_q, of_d, cnd_q, cnd_d;
  logic accept, eval, push, pop, fifo_full, fifo_empty;
  logic [3:0] eff_dst;

  // in_ready follows occupancy only, so a full FIFO blocks even on a same-cycle pop.
  assign in_ready = ~fifo_full;
  assign accept   = in_valid & in_ready;
  assign eval     = cond_eval(ifun, zf_q, sf_q, of_q);
  assign eff_dst  = (is_cond && !eval) ? RNONE : dst;
  assign push     = accept && (eff_dst != RNONE);
  assign wb_valid = ~fifo_empty;
  assign pop      = wb_valid & wb_ready;

  always_comb begin
    zf_d  = zf_q;
    sf_d  = sf_q;
    of_d  = of_q;
    cnd_d = cnd_q;
    if (accept && is_cond) begin
      cnd_d = eval;
    end
    if (accept && set_cc) begin
      zf_d = (alu_out == '0);
      sf_d = alu_out[W-1];
      of_d = alu_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf_q  <= CC_ZF_RST;
      sf_q  <= CC_SF_RST;
      of_q  <= CC_OF_RST;
      cnd_q <= 1'b0;
    end else begin
      zf_q  <= zf_d;
      sf_q  <= sf_d;
      of_q  <= of_d;
      cnd_q <= cnd_d;
    end
  end

  assign cc_zf = zf_q;
  assign cc_sf = sf_q;
  assign cc_of = of_q;
  assign cnd   = cnd_q;

  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_wb_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dst (eff_dst),
    .push_val (alu_out),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dst (wb_dst),
    .head_val (wb_val)
  );

endmodule
